// File: rtl/dsp_fetch_seq.sv
// dsp_fetch_seq -- program counter and instruction fetch sequencer for a small DSP core.
//
// The PC register drives the ROM address directly, so the instruction for the current PC
// appears on instruction_out in the same cycle. Each cycle the next PC is chosen from
// (highest first): reset, stall, return, call, jump, hardware-loop branch, PC+1.
// Calls and returns use a small return-address stack. stack_err is a sticky flag for
// overflow (call while full) and underflow (return while empty).
//
// Optional feature: define FETCH_HWLOOP_EN to build in a zero-overhead hardware loop.
// The loop adds the loop_set/loop_end/loop_cnt inputs and the loop_active output.
//
// Ports:
//   clk             in   single clock, rising edge
//   rst             in   synchronous active-high reset
//   stall           in   hold PC and all state this cycle
//   jump_flag       in   unconditional jump to jump_addr
//   call_flag       in   push PC+1, then jump to jump_addr
//   ret_flag        in   pop the return stack into PC
//   jump_addr       in   jump/call target [ADDR_W]
//   read_addr       out  ROM address (equals the PC) [ADDR_W]
//   read_data       in   ROM data [INST_W]
//   instruction_out out  read_data passed through combinationally [INST_W]
//   stack_err       out  sticky overflow/underflow flag
//   stack_level     out  number of valid stack entries
//   loop_set        in   (FETCH_HWLOOP_EN) start a loop body at PC+1
//   loop_end        in   (FETCH_HWLOOP_EN) address of the last loop instruction
//   loop_cnt        in   (FETCH_HWLOOP_EN) number of iterations
//   loop_active     out  (FETCH_HWLOOP_EN) a loop is armed
module dsp_fetch_seq #(
   parameter int              ADDR_W      = 16,
   parameter int              INST_W      = 32,
   parameter int              STACK_DEPTH = 4,
   parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              stall,
   input  logic                              jump_flag,
   input  logic                              call_flag,
   input  logic                              ret_flag,
   input  logic [ADDR_W-1:0]                 jump_addr,
   output logic [ADDR_W-1:0]                 read_addr,
   input  logic [INST_W-1:0]                 read_data,
   output logic [INST_W-1:0]                 instruction_out,
   output logic                              stack_err,
`ifdef FETCH_HWLOOP_EN
   input  logic                              loop_set,
   input  logic [ADDR_W-1:0]                 loop_end,
   input  logic [15:0]                       loop_cnt,
   output logic                              loop_active,
`endif
   output logic [$clog2(STACK_DEPTH+1)-1:0]  stack_level
);

   localparam int LVL_W = $clog2(STACK_DEPTH + 1);
   localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] pc_d;
   logic [ADDR_W-1:0] pc_inc;
   logic [LVL_W-1:0]  lvl_q;
   logic [LVL_W-1:0]  lvl_d;
   logic              err_q;
   logic              err_d;
   logic              push;
   logic [IDX_W-1:0]  top_idx;
   logic [IDX_W-1:0]  wr_idx;
   logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

`ifdef FETCH_HWLOOP_EN
   logic [ADDR_W-1:0] loop_start_q;
   logic [ADDR_W-1:0] loop_start_d;
   logic [ADDR_W-1:0] loop_end_q;
   logic [ADDR_W-1:0] loop_end_d;
   logic [15:0]       loop_rem_q;
   logic [15:0]       loop_rem_d;
   logic              loop_act_q;
   logic              loop_act_d;
`endif

   // PC+1 naturally wraps at 2^ADDR_W. The stack grows upward: entry lvl_q-1 is the top,
   // entry lvl_q is the next free slot.
   assign pc_inc  = pc_q + ADDR_W'(1);
   assign top_idx = IDX_W'(lvl_q - LVL_W'(1));
   assign wr_idx  = IDX_W'(lvl_q);

   // Next-state selection. Stall freezes everything; otherwise the flow-control inputs are
   // checked in priority order. A simultaneous call and return performs only the return.
   // A full-stack call still jumps but drops the return address; an empty-stack return
   // falls through to PC+1. Both cases raise the sticky error flag.
   always_comb begin
      pc_d  = pc_inc;
      lvl_d = lvl_q;
      err_d = err_q;
      push  = 1'b0;
`ifdef FETCH_HWLOOP_EN
      loop_start_d = loop_start_q;
      loop_end_d   = loop_end_q;
      loop_rem_d   = loop_rem_q;
      loop_act_d   = loop_act_q;
`endif
      if (stall) begin
         pc_d = pc_q;
      end else if (ret_flag) begin
         if (lvl_q != '0) begin
            pc_d  = stack_q[top_idx];
            lvl_d = lvl_q - LVL_W'(1);
         end else begin
            err_d = 1'b1;
         end
      end else if (call_flag) begin
         pc_d = jump_addr;
         if (lvl_q == LVL_W'(STACK_DEPTH)) begin
            err_d = 1'b1;
         end else begin
            push  = 1'b1;
            lvl_d = lvl_q + LVL_W'(1);
         end
      end else if (jump_flag) begin
         pc_d = jump_addr;
      end
`ifdef FETCH_HWLOOP_EN
      else if (loop_act_q && !loop_set && (pc_q == loop_end_q)) begin
         if (loop_rem_q > 16'd1) begin
            pc_d       = loop_start_q;
            loop_rem_d = loop_rem_q - 16'd1;
         end else begin
            loop_act_d = 1'b0;
         end
      end
`endif

`ifdef FETCH_HWLOOP_EN
      // Arming a loop replaces any loop in progress; a zero count arms nothing.
      if (!stall && loop_set) begin
         loop_start_d = pc_inc;
         loop_end_d   = loop_end;
         loop_rem_d   = loop_cnt;
         loop_act_d   = (loop_cnt != 16'd0);
      end
`endif
   end

   // Control state registers with synchronous reset; reset wins over every other input
   // so any call or loop in progress is abandoned cleanly.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q  <= RESET_VEC;
         lvl_q <= '0;
         err_q <= 1'b0;
      end else begin
         pc_q  <= pc_d;
         lvl_q <= lvl_d;
         err_q <= err_d;
      end
   end

   // Return-address storage. Entries are not cleared on reset because stack_level alone
   // decides which entries are valid.
   always_ff @(posedge clk) begin
      if (!rst && push) begin
         stack_q[wr_idx] <= pc_inc;
      end
   end

`ifdef FETCH_HWLOOP_EN
   // Hardware-loop registers: body start, last address, remaining passes, armed flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         loop_start_q <= '0;
         loop_end_q   <= '0;
         loop_rem_q   <= '0;
         loop_act_q   <= 1'b0;
      end else begin
         loop_start_q <= loop_start_d;
         loop_end_q   <= loop_end_d;
         loop_rem_q   <= loop_rem_d;
         loop_act_q   <= loop_act_d;
      end
   end

   assign loop_active = loop_act_q;
`endif

   assign read_addr       = pc_q;
   assign instruction_out = read_data;
   assign stack_err       = err_q;
   assign stack_level     = lvl_q;

endmodule

// File: tb/tb_dsp_fetch_seq.sv
// tb_dsp_fetch_seq -- directed testbench for dsp_fetch_seq with default parameters.
// A queue-based reference model tracks the expected PC, return stack and error flag and
// is compared against the DUT on every falling edge; directed sequences also check
// hand-computed PC values. Build with FETCH_HWLOOP_EN to include the hardware-loop tests.
module tb_dsp_fetch_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        jump_flag;
   logic        call_flag;
   logic        ret_flag;
   logic [15:0] jump_addr;
   logic [15:0] read_addr;
   logic [31:0] read_data;
   logic [31:0] instruction_out;
   logic        stack_err;
   logic [2:0]  stack_level;
`ifdef FETCH_HWLOOP_EN
   logic        loop_set;
   logic [15:0] loop_end;
   logic [15:0] loop_cnt;
   logic        loop_active;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   bit check_en = 1'b0;

   // Reference model state
   logic [15:0] m_pc;
   logic [15:0] m_stack[$];
   bit          m_err;
`ifdef FETCH_HWLOOP_EN
   logic [15:0] m_start;
   logic [15:0] m_end;
   logic [15:0] m_rem;
   bit          m_act;
`endif

   always #5 clk = ~clk;

   // ROM contents derived from the address so instruction_out is checkable.
   assign read_data = {~read_addr, read_addr};

   dsp_fetch_seq dut (
      .clk             (clk),
      .rst             (rst),
      .stall           (stall),
      .jump_flag       (jump_flag),
      .call_flag       (call_flag),
      .ret_flag        (ret_flag),
      .jump_addr       (jump_addr),
      .read_addr       (read_addr),
      .read_data       (read_data),
      .instruction_out (instruction_out),
      .stack_err       (stack_err),
`ifdef FETCH_HWLOOP_EN
      .loop_set        (loop_set),
      .loop_end        (loop_end),
      .loop_cnt        (loop_cnt),
      .loop_active     (loop_active),
`endif
      .stack_level     (stack_level)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs at the falling edge, then return at the next falling edge.
   task automatic applyStimulus(input logic r, input logic s, input logic j, input logic c,
                                input logic rt, input logic [15:0] a);
      rst       = r;
      stall     = s;
      jump_flag = j;
      call_flag = c;
      ret_flag  = rt;
      jump_addr = a;
      @(posedge clk);
      @(negedge clk);
   endtask

   // Reference model: applies the sequencing rules with a queue as the return stack.
   always @(posedge clk) begin : model_blk
      logic [15:0] nxt;
      if (rst) begin
         m_pc = 16'h0000;
         m_stack.delete();
         m_err = 1'b0;
`ifdef FETCH_HWLOOP_EN
         m_act = 1'b0;
         m_rem = 16'd0;
`endif
      end else if (!stall) begin
         nxt = m_pc + 16'd1;
         if (ret_flag) begin
            if (m_stack.size() > 0) nxt = m_stack.pop_back();
            else m_err = 1'b1;
         end else if (call_flag) begin
            if (m_stack.size() == 4) m_err = 1'b1;
            else m_stack.push_back(m_pc + 16'd1);
            nxt = jump_addr;
         end else if (jump_flag) begin
            nxt = jump_addr;
         end
`ifdef FETCH_HWLOOP_EN
         else if (m_act && !loop_set && m_pc == m_end) begin
            if (m_rem > 16'd1) begin
               nxt   = m_start;
               m_rem = m_rem - 16'd1;
            end else begin
               m_act = 1'b0;
            end
         end
         if (loop_set) begin
            m_start = m_pc + 16'd1;
            m_end   = loop_end;
            m_rem   = loop_cnt;
            m_act   = (loop_cnt != 16'd0);
         end
`endif
         m_pc = nxt;
      end
   end

   // Every-cycle comparison of the DUT against the model.
   always @(negedge clk) begin
      if (check_en) begin
         checkOutput("model_pc",    32'(read_addr),       32'(m_pc));
         checkOutput("model_level", 32'(stack_level),     32'(m_stack.size()));
         checkOutput("model_err",   32'(stack_err),       32'(m_err));
         checkOutput("model_instr", instruction_out,      {~m_pc, m_pc});
`ifdef FETCH_HWLOOP_EN
         checkOutput("model_loop",  32'(loop_active),     32'(m_act));
`endif
      end
   end

   initial begin
      logic [15:0] exp_ret [4];
`ifdef FETCH_HWLOOP_EN
      logic [15:0] exp_loop [6];
`endif
      exp_ret = '{16'h0301, 16'h0201, 16'h0101, 16'h0051};
      rst = 1'b1; stall = 1'b0; jump_flag = 1'b0; call_flag = 1'b0; ret_flag = 1'b0;
      jump_addr = 16'h0000;
`ifdef FETCH_HWLOOP_EN
      loop_set = 1'b0; loop_end = 16'h0000; loop_cnt = 16'h0000;
`endif
      @(negedge clk);
      @(negedge clk);
      check_en = 1'b1;
      checkOutput("rst_pc",    32'(read_addr),   32'h0);
      checkOutput("rst_level", 32'(stack_level), 32'h0);
      checkOutput("rst_err",   32'(stack_err),   32'h0);

      // Free-running count after reset
      for (int i = 1; i <= 4; i++) begin
         applyStimulus(0, 0, 0, 0, 0, 16'h0);
         checkOutput("free_pc", 32'(read_addr), 32'(i));
      end

      // Call and return
      applyStimulus(0, 0, 1, 0, 0, 16'h0010);
      checkOutput("jump_pc", 32'(read_addr), 32'h10);
      applyStimulus(0, 0, 0, 1, 0, 16'h0040);
      checkOutput("call_pc", 32'(read_addr), 32'h40);
      checkOutput("call_level", 32'(stack_level), 32'h1);
      applyStimulus(0, 0, 0, 0, 0, 16'h0);
      checkOutput("body_pc", 32'(read_addr), 32'h41);
      applyStimulus(0, 0, 0, 0, 0, 16'h0);
      checkOutput("body_pc", 32'(read_addr), 32'h42);
      applyStimulus(0, 0, 0, 0, 1, 16'h0);
      checkOutput("ret_pc", 32'(read_addr), 32'h11);
      checkOutput("ret_level", 32'(stack_level), 32'h0);

      // Stall with a pending jump
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 1, 1, 0, 0, 16'h0080);
         checkOutput("stall_pc", 32'(read_addr), 32'h11);
      end
      applyStimulus(0, 0, 1, 0, 0, 16'h0080);
      checkOutput("unstall_jump_pc", 32'(read_addr), 32'h80);
      for (int i = 0; i < 2; i++) begin
         applyStimulus(0, 1, 1, 0, 0, 16'h0090);
         checkOutput("stall_pc", 32'(read_addr), 32'h80);
      end
      applyStimulus(0, 0, 0, 0, 0, 16'h0090);
      checkOutput("unstall_nojump_pc", 32'(read_addr), 32'h81);

      // Simultaneous call and return performs only the return
      applyStimulus(0, 0, 0, 1, 0, 16'h0060);
      checkOutput("call2_pc", 32'(read_addr), 32'h60);
      applyStimulus(0, 0, 0, 1, 1, 16'h0099);
      checkOutput("callret_pc", 32'(read_addr), 32'h82);
      checkOutput("callret_level", 32'(stack_level), 32'h0);

      // PC wrap and a call pushing the wrapped return address
      applyStimulus(0, 0, 1, 0, 0, 16'hFFFF);
      applyStimulus(0, 0, 0, 0, 0, 16'h0);
      checkOutput("wrap_pc", 32'(read_addr), 32'h0);
      applyStimulus(0, 0, 1, 0, 0, 16'hFFFF);
      applyStimulus(0, 0, 0, 1, 0, 16'h0010);
      applyStimulus(0, 0, 0, 0, 1, 16'h0);
      checkOutput("wrap_ret_pc", 32'(read_addr), 32'h0);

      // Overflow on the fifth nested call, then unwind
      applyStimulus(0, 0, 1, 0, 0, 16'h0050);
      for (int i = 1; i <= 4; i++) begin
         applyStimulus(0, 0, 0, 1, 0, 16'(i * 256));
         checkOutput("nest_level", 32'(stack_level), 32'(i));
      end
      checkOutput("nest_err", 32'(stack_err), 32'h0);
      applyStimulus(0, 0, 0, 1, 0, 16'h0500);
      checkOutput("ovf_pc", 32'(read_addr), 32'h500);
      checkOutput("ovf_level", 32'(stack_level), 32'h4);
      checkOutput("ovf_err", 32'(stack_err), 32'h1);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 0, 0, 0, 1, 16'h0);
         checkOutput("unwind_pc", 32'(read_addr), 32'(exp_ret[i]));
         checkOutput("unwind_level", 32'(stack_level), 32'(3 - i));
      end
      checkOutput("unwind_err", 32'(stack_err), 32'h1);

      // Reset clears the error and abandons a call in progress
      applyStimulus(1, 0, 0, 0, 0, 16'h0);
      checkOutput("rst2_err", 32'(stack_err), 32'h0);
      applyStimulus(0, 0, 0, 1, 0, 16'h0030);
      checkOutput("call3_level", 32'(stack_level), 32'h1);
      applyStimulus(1, 0, 0, 1, 0, 16'h0070);
      checkOutput("rst_mid_pc", 32'(read_addr), 32'h0);
      checkOutput("rst_mid_level", 32'(stack_level), 32'h0);

      // Underflow is sticky until reset
      applyStimulus(0, 0, 1, 0, 0, 16'h0020);
      applyStimulus(0, 0, 0, 0, 1, 16'h0);
      checkOutput("unf_pc", 32'(read_addr), 32'h21);
      checkOutput("unf_err", 32'(stack_err), 32'h1);
      applyStimulus(0, 0, 0, 0, 0, 16'h0);
      checkOutput("unf_sticky", 32'(stack_err), 32'h1);
      applyStimulus(1, 0, 0, 0, 0, 16'h0);
      checkOutput("unf_cleared", 32'(stack_err), 32'h0);

`ifdef FETCH_HWLOOP_EN
      // Three-pass loop over 6..7
      exp_loop = '{16'h7, 16'h6, 16'h7, 16'h6, 16'h7, 16'h8};
      applyStimulus(0, 0, 1, 0, 0, 16'h0005);
      loop_set = 1'b1; loop_end = 16'h0007; loop_cnt = 16'd3;
      applyStimulus(0, 0, 0, 0, 0, 16'h0);
      loop_set = 1'b0;
      checkOutput("loop_pc", 32'(read_addr), 32'h6);
      checkOutput("loop_armed", 32'(loop_active), 32'h1);
      for (int i = 0; i < 6; i++) begin
         applyStimulus(0, 0, 0, 0, 0, 16'h0);
         checkOutput("loop_pc", 32'(read_addr), 32'(exp_loop[i]));
      end
      checkOutput("loop_done", 32'(loop_active), 32'h0);

      // Zero count never arms
      applyStimulus(0, 0, 1, 0, 0, 16'h0005);
      loop_set = 1'b1; loop_cnt = 16'd0;
      applyStimulus(0, 0, 0, 0, 0, 16'h0);
      loop_set = 1'b0;
      checkOutput("loop0_active", 32'(loop_active), 32'h0);
      applyStimulus(0, 0, 0, 0, 0, 16'h0);
      checkOutput("loop0_pc", 32'(read_addr), 32'h7);
      applyStimulus(0, 0, 0, 0, 0, 16'h0);
      checkOutput("loop0_pc", 32'(read_addr), 32'h8);
`endif

      check_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
